// File: rtl/mips_funct_pkg.sv
// Shared function codes and controller state encoding for the MULTU/HI/LO path.
// Imported by mult_ctrl, hilo_regs and the shift-add Multiplier so that all
// three agree on the funct codes and on the Signal value that publishes the
// product.
package mips_funct_pkg;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_OUT   = 6'b111111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2,
    CAPT = 2'd3
  } mstate_t;

  // Requests that touch HI/LO or the multiplier; these must wait while a
  // multiply is in flight.
  function automatic logic is_hilo_op(input logic [5:0] f);
    return (f == F_MULTU) || (f == F_MFHI) || (f == F_MFLO) ||
           (f == F_MTHI)  || (f == F_MTLO);
  endfunction

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-low reset, clears HI and LO
//   hi_we    - MTHI write enable (wdata -> HI)
//   lo_we    - MTLO write enable (wdata -> LO)
//   wdata    - MT write data
//   prod_we  - product capture enable (prod[63:32] -> HI, prod[31:0] -> LO)
//   prod     - 64-bit product from the multiplier
//   rd_hi    - read select: 1 = HI, 0 = LO
//   rd_data  - combinational read data
module hilo_regs
  import mips_funct_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        prod_we,
  input  logic [63:0] prod,
  input  logic        rd_hi,
  output logic [31:0] rd_data
);

  logic [31:0] hi;
  logic [31:0] lo;

  // Product capture wins over MT writes; the controller never raises both in
  // the same cycle, the priority only keeps the intent explicit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (prod_we) begin
      hi <= prod[63:32];
      lo <= prod[31:0];
    end else begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

  assign rd_data = rd_hi ? hi : lo;

endmodule

// File: rtl/mult_ctrl.sv
// Sequencing controller for the 32-cycle shift-add Multiplier in EX.
// Accepts MULTU/MTHI/MTLO/MFHI/MFLO, drives the multiplier for ITER iteration
// cycles plus two publish cycles, captures the product into HI/LO and stalls
// HI/LO requests while a multiply is in flight.
// Ports:
//   clk, reset          - clock; synchronous active-low reset
//   req, funct          - request valid and function code
//   rs_data, rt_data    - MULTU operands / MT write data (rs)
//   mf_data             - HI (MFHI) or LO (otherwise), combinational
//   stall, busy, done   - pipeline hold, multiply in flight, capture pulse
//   mul_signal          - Multiplier.Signal
//   mul_dataA/B         - Multiplier operands (latched copies)
//   mul_reset           - Multiplier.reset, active-high
//   mul_dataOut         - Multiplier product
module mult_ctrl
  import mips_funct_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] mf_data,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [5:0]  mul_signal,
  output logic [31:0] mul_dataA,
  output logic [31:0] mul_dataB,
  output logic        mul_reset,
  input  logic [63:0] mul_dataOut
);

  localparam logic [5:0] ITER_LAST = 6'(ITER - 1);

  mstate_t     state;
  mstate_t     state_nxt;
  logic [5:0]  cnt;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        accept_mult;
  logic        mthi_we;
  logic        mtlo_we;
  logic        idle_req;

  assign idle_req    = (state == IDLE) && req;
  assign accept_mult = idle_req && (funct == F_MULTU);
  assign mthi_we     = idle_req && (funct == F_MTHI);
  assign mtlo_we     = idle_req && (funct == F_MTLO);

  // Clearing the multiplier on the accept cycle guarantees its output
  // register holds no stale product when the iterations begin.
  assign mul_reset = ~reset | accept_mult;

  assign stall     = busy && req && is_hilo_op(funct);
  assign mul_dataA = opa;
  assign mul_dataB = opb;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
    end else begin
      state <= state_nxt;
      if (accept_mult) begin
        opa <= rs_data;
        opb <= rt_data;
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + 6'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    mul_signal = 6'b000000;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept_mult) state_nxt = RUN;
      end
      RUN: begin
        busy       = 1'b1;
        mul_signal = F_MULTU;
        if (cnt == ITER_LAST) state_nxt = OUT;
      end
      OUT: begin
        busy       = 1'b1;
        mul_signal = F_OUT;
        state_nxt  = CAPT;
      end
      CAPT: begin
        busy       = 1'b1;
        mul_signal = F_OUT;
        // A reset landing on the capture cycle aborts the operation, so the
        // pulse is suppressed rather than announcing a product that is lost.
        done       = reset;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  hilo_regs u_hilo (
    .clk     (clk),
    .reset   (reset),
    .hi_we   (mthi_we),
    .lo_we   (mtlo_we),
    .wdata   (rs_data),
    .prod_we (state == CAPT),
    .prod    (mul_dataOut),
    .rd_hi   (funct == F_MFHI),
    .rd_data (mf_data)
  );

endmodule

// File: tb/tb_mult_ctrl.sv
module tb_mult_ctrl;
  import mips_funct_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic [31:0] mf_data;
  logic        stall, busy, done;
  logic [5:0]  mul_signal;
  logic [31:0] mul_dataA, mul_dataB;
  logic        mul_reset;
  logic [63:0] mul_dataOut;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  always #5 clk = ~clk;

  mult_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .funct      (funct),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .mf_data    (mf_data),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .mul_signal (mul_signal),
    .mul_dataA  (mul_dataA),
    .mul_dataB  (mul_dataB),
    .mul_reset  (mul_reset),
    .mul_dataOut(mul_dataOut)
  );

  // Behavioural Multiplier: counts iteration cycles since its last clear and
  // only publishes a true product after exactly 32 of them.
  int          mcnt = 0;
  logic [63:0] mdout = 64'd0;
  always @(posedge clk) begin
    if (mul_reset) begin
      mcnt  <= 0;
      mdout <= 64'd0;
    end else if (mul_signal == F_MULTU) begin
      mcnt <= mcnt + 1;
    end else if (mul_signal == F_OUT) begin
      mdout <= (mcnt == 32) ? ({32'd0, mul_dataA} * {32'd0, mul_dataB})
                            : 64'hBADBADBADBADBAD0;
    end
  end
  assign mul_dataOut = mdout;

  // Full MULTU: accept, 32 RUN + OUT + CAPT cycles, then HI/LO readback.
  // With hold=1 a second MULTU is presented during CAPT and left pending.
  task automatic run_multu(input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    req = 1'b1; funct = F_MULTU; rs_data = a; rt_data = b;
    @(negedge clk);
    checks++;
    if (mul_reset !== 1'b1 || stall !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL accept: mul_reset=%b stall=%b busy=%b, want 1 0 0", mul_reset, stall, busy);
    end
    @(posedge clk); #1;
    req = 1'b0; rs_data = $urandom; rt_data = $urandom;
    for (int k = 0; k < 34; k++) begin
      funct = k[0] ? F_MFHI : F_MFLO;
      if (hold && k == 33) begin req = 1'b1; funct = F_MULTU; end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || mul_signal !== ((k < 32) ? F_MULTU : F_OUT) || done !== (k == 33) ||
          mul_dataA !== a || mul_dataB !== b || mul_reset !== 1'b0) begin
        failures++;
        $display("FAIL seq k=%0d: busy=%b sig=%h done=%b A=%h B=%h mrst=%b, want A=%h B=%h",
                 k, busy, mul_signal, done, mul_dataA, mul_dataB, mul_reset, a, b);
      end
      checks++;
      if (hold && k == 33) begin
        if (stall !== 1'b1) begin
          failures++;
          $display("FAIL capt_stall: stall=%b want 1", stall);
        end
      end else if (stall !== 1'b0 || mf_data !== (k[0] ? exp_hi : exp_lo)) begin
        failures++;
        $display("FAIL hold_hilo k=%0d: stall=%b mf_data=%h want 0 %h", k, stall, mf_data,
                 k[0] ? exp_hi : exp_lo);
      end
      @(posedge clk); #1;
    end
    exp_hi = p[63:32]; exp_lo = p[31:0];
    if (!hold) begin
      funct = F_MFHI;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || mf_data !== exp_hi) begin
        failures++;
        $display("FAIL result_hi %h*%h: busy=%b done=%b HI=%h want %h", a, b, busy, done, mf_data, exp_hi);
      end
      funct = F_MFLO; #1;
      checks++;
      if (mf_data !== exp_lo) begin
        failures++;
        $display("FAIL result_lo %h*%h: LO=%h want %h", a, b, mf_data, exp_lo);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || mul_signal !== 6'd0 ||
        mul_reset !== 1'b1 || mul_dataA !== 32'd0 || mul_dataB !== 32'd0) begin
      failures++;
      $display("FAIL reset_out: busy=%b done=%b stall=%b sig=%h mrst=%b A=%h B=%h",
               busy, done, stall, mul_signal, mul_reset, mul_dataA, mul_dataB);
    end
    @(posedge clk); #1;
    reset = 1'b1; funct = F_MFHI;
    @(negedge clk);
    checks++;
    if (mf_data !== 32'd0 || mul_reset !== 1'b0) begin
      failures++;
      $display("FAIL reset_hi: HI=%h mrst=%b want 0 0", mf_data, mul_reset);
    end
    funct = F_MFLO; #1;
    checks++;
    if (mf_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_lo: LO=%h want 0", mf_data);
    end
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_multu_basic;
    run_multu(32'd3, 32'd5, 1'b0);
    run_multu(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 4; i++) run_multu($urandom, $urandom, 1'b0);
  endtask

  task automatic test_mflo_stall;
    req = 1'b1; funct = F_MULTU; rs_data = 32'h10000; rt_data = 32'h10000;
    @(posedge clk); #1;
    for (int k = 0; k < 34; k++) begin
      req = 1'b0; funct = 6'd0;
      if (k == 2) begin req = 1'b1; funct = 6'h20; end
      if (k >= 5) begin req = 1'b1; funct = F_MFLO; end
      @(negedge clk);
      checks++;
      if (stall !== (k >= 5) || busy !== 1'b1) begin
        failures++;
        $display("FAIL mflo_stall k=%0d: stall=%b busy=%b want %b 1", k, stall, busy, k >= 5);
      end
      @(posedge clk); #1;
    end
    exp_hi = 32'd1; exp_lo = 32'd0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mf_data !== 32'd0) begin
      failures++;
      $display("FAIL mflo_after: stall=%b LO=%h want 0 00000000", stall, mf_data);
    end
    funct = F_MFHI; #1;
    checks++;
    if (stall !== 1'b0 || mf_data !== 32'd1) begin
      failures++;
      $display("FAIL mfhi_after: stall=%b HI=%h want 0 00000001", stall, mf_data);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic test_mt;
    logic [31:0] v;
    v = $urandom;
    req = 1'b1; funct = F_MTHI; rs_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL mthi_stall: stall=%b want 0", stall); end
    @(posedge clk); #1;
    funct = F_MTLO; rs_data = v;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL mtlo_stall: stall=%b want 0", stall); end
    @(posedge clk); #1;
    exp_hi = 32'hDEADBEEF; exp_lo = v;
    funct = F_MFHI;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mf_data !== exp_hi) begin
      failures++;
      $display("FAIL mfhi_mt: stall=%b HI=%h want 0 %h", stall, mf_data, exp_hi);
    end
    funct = F_MFLO; #1;
    checks++;
    if (stall !== 1'b0 || mf_data !== exp_lo) begin
      failures++;
      $display("FAIL mflo_mt: stall=%b LO=%h want 0 %h", stall, mf_data, exp_lo);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic test_reset_mid;
    int ndone;
    req = 1'b1; funct = F_MULTU; rs_data = 32'd7; rt_data = 32'd9;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (mul_reset !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL midreset: mrst=%b done=%b want 1 0", mul_reset, done);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    funct = F_MFHI;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mf_data !== 32'd0) begin
      failures++;
      $display("FAIL midreset_hi: busy=%b HI=%h want 0 0", busy, mf_data);
    end
    funct = F_MFLO; #1;
    checks++;
    if (mf_data !== 32'd0) begin failures++; $display("FAIL midreset_lo: LO=%h want 0", mf_data); end
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy !== 1'b0) ndone++;
    end
    checks++;
    if (ndone != 0) begin failures++; $display("FAIL midreset_quiet: active cycles=%0d want 0", ndone); end
    run_multu(32'd2, 32'd2, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_multu(32'd6, 32'd7, 1'b1);
    checks++;
    if (exp_lo !== 32'd42) begin failures++; $display("FAIL b2b_model: LO=%0d want 42", exp_lo); end
    run_multu(32'd8, 32'd8, 1'b0);
  endtask

  initial begin
    test_reset();
    test_multu_basic();
    test_mflo_stall();
    test_mt();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion before 200000");
    $fatal(1);
  end

endmodule
